// File: rtl/adr_range_scanner_pkg.sv
// Shared definitions for the address-range scan path.
// Contents: default address/data widths and the scanner state encoding.
// The address-compare stage's consumers import this package too, so keep
// additions backward compatible.
package adr_scan_pkg;

  localparam int ADR_W  = 5;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } scan_state_e;

endpackage

// File: rtl/adr_range_scanner_if.sv
// Bundle between the scan controller, the scanner and its memory port.
// Signals:
//   go, start_adr, end_adr, same, key   request from the controller
//   busy, done, hit, hit_adr            status back to the controller
//   rd_en, rd_adr                       read request to the memory
//   rd_data                             memory word, one cycle after rd_en
// master: controller + memory side; slave: the scanner.
interface adr_range_scanner_if;
  import adr_scan_pkg::*;

  logic              go;
  logic [ADR_W-1:0]  start_adr;
  logic [ADR_W-1:0]  end_adr;
  logic              same;
  logic [DATA_W-1:0] key;
  logic              rd_en;
  logic [ADR_W-1:0]  rd_adr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              hit;
  logic [ADR_W-1:0]  hit_adr;

  modport master (
    output go, start_adr, end_adr, same, key, rd_data,
    input  rd_en, rd_adr, busy, done, hit, hit_adr
  );

  modport slave (
    input  go, start_adr, end_adr, same, key, rd_data,
    output rd_en, rd_adr, busy, done, hit, hit_adr
  );

endinterface

// File: rtl/adr_range_scanner_counter.sv
// Scan address counter.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   load         capture start/end/same, count starts at start_adr
//   start_adr, end_adr, same   range bounds sampled on load
//   en           advance one address
//   cnt          current address
//   is_last      current address is the final one of the range
// The count saturates at the end address, so a range ending at the top
// of the address space never wraps back to 0.
module scan_adr_counter
  import adr_scan_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [ADR_W-1:0] start_adr,
  input  logic [ADR_W-1:0] end_adr,
  input  logic             same,
  input  logic             en,
  output logic [ADR_W-1:0] cnt,
  output logic             is_last
);

  logic [ADR_W-1:0] end_q;
  logic             same_q;

  assign is_last = same_q || (cnt == end_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      end_q  <= '0;
      same_q <= 1'b0;
    end else if (load) begin
      cnt    <= start_adr;
      end_q  <= end_adr;
      same_q <= same;
    end else if (en && !is_last) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adr_range_scanner.sv
// Range scanner: walks start..end through a synchronous-read memory and
// stops at the first word equal to the key.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous active-low reset
//   bus    adr_range_scanner_if.slave (request, status, memory port)
//
// state | meaning
// IDLE  | waiting for go, outputs idle
// SCAN  | issuing one read per cycle, comparing the previous word
// LAST  | end address issued, comparing the final word only
// DONE  | one-cycle done pulse, then back to IDLE
module adr_range_scanner
  import adr_scan_pkg::*;
(
  input  logic clk,
  input  logic reset,
  adr_range_scanner_if.slave bus
);

  scan_state_e       state_q, state_d;
  logic [DATA_W-1:0] key_q;
  logic              vld_q;
  logic [ADR_W-1:0]  adr_q;
  logic              hit_q;
  logic [ADR_W-1:0]  hit_adr_q;

  logic [ADR_W-1:0]  cnt;
  logic              is_last;
  logic              accept;
  logic              empty;
  logic              match;
  logic              rd_en_c;

  assign accept = (state_q == IDLE) && bus.go;
  assign empty  = !bus.same && (bus.start_adr > bus.end_adr);

  // vld_q marks a word returning this cycle; gating by state drops any
  // data arriving after the scan has been resolved.
  assign match   = vld_q && ((state_q == SCAN) || (state_q == LAST)) &&
                   (bus.rd_data == key_q);
  assign rd_en_c = (state_q == SCAN) && !match;

  scan_adr_counter u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .start_adr (bus.start_adr),
    .end_adr   (bus.end_adr),
    .same      (bus.same),
    .en        (rd_en_c),
    .cnt       (cnt),
    .is_last   (is_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.go) state_d = empty ? DONE : SCAN;
      SCAN: begin
        if (match)        state_d = DONE;
        else if (is_last) state_d = LAST;
      end
      LAST: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      key_q     <= '0;
      vld_q     <= 1'b0;
      adr_q     <= '0;
      hit_q     <= 1'b0;
      hit_adr_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= rd_en_c;
      adr_q   <= cnt;
      if (accept) begin
        key_q     <= bus.key;
        hit_q     <= 1'b0;
        hit_adr_q <= '0;
      end else if (match) begin
        hit_q     <= 1'b1;
        hit_adr_q <= adr_q;
      end
    end
  end

  assign bus.rd_en   = rd_en_c;
  assign bus.rd_adr  = rd_en_c ? cnt : '0;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.hit     = hit_q;
  assign bus.hit_adr = hit_adr_q;

endmodule

// File: tb/tb_adr_range_scanner.sv
module tb_adr_range_scanner;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  adr_range_scanner_if bus();

  adr_range_scanner dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [7:0] mem [32];

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_adr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: per-scan summary (range size, index of first matching word),
  // from which every output is derived as a function of the cycle number.
  bit armed    = 1'b0;
  bit m_active = 1'b0;
  bit m_empty;
  int m_n, m_hitk, m_start;
  int cyc = 0;

  bit   done_seen = 1'b0;
  int   done_at   = 0;
  int   n_reads   = 0;
  logic obs_hit;
  int   obs_hit_adr;

  function automatic int done_cyc();
    if (m_empty) return 1;
    if (m_hitk >= 0) return m_hitk + 3;
    return m_n + 2;
  endfunction

  function automatic int read_cnt();
    if (m_empty) return 0;
    if (m_hitk >= 0) return m_hitk + 1;
    return m_n;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      armed     = 1'b1;
      m_active  = 1'b0;
      done_seen = 1'b0;
    end else if (bus.go && (!m_active || cyc > done_cyc())) begin
      m_start = int'(bus.start_adr);
      m_empty = !bus.same && (bus.start_adr > bus.end_adr);
      if (m_empty)       m_n = 0;
      else if (bus.same) m_n = 1;
      else               m_n = int'(bus.end_adr) - int'(bus.start_adr) + 1;
      m_hitk = -1;
      for (int i = 0; i < m_n; i++)
        if (m_hitk < 0 && mem[m_start + i] == bus.key) m_hitk = i;
      m_active  = 1'b1;
      cyc       = 1;
      done_seen = 1'b0;
      n_reads   = 0;
    end else if (m_active) begin
      cyc++;
    end
  end

  always @(negedge clk) begin : cmp
    int   d;
    logic e_rd, e_busy, e_done, e_hit;
    int   e_adr, e_hadr;
    if (armed) begin
      e_rd = 0; e_busy = 0; e_done = 0; e_hit = 0; e_adr = 0; e_hadr = 0;
      if (m_active) begin
        d      = done_cyc();
        e_rd   = (cyc <= read_cnt());
        e_adr  = e_rd ? m_start + cyc - 1 : 0;
        e_busy = (cyc <= d);
        e_done = (cyc == d);
        e_hit  = (cyc >= d) && (m_hitk >= 0);
        e_hadr = e_hit ? m_start + m_hitk : 0;
      end
      chk("rd_en",   32'(bus.rd_en),   32'(e_rd));
      chk("rd_adr",  32'(bus.rd_adr),  e_adr);
      chk("busy",    32'(bus.busy),    32'(e_busy));
      chk("done",    32'(bus.done),    32'(e_done));
      chk("hit",     32'(bus.hit),     32'(e_hit));
      chk("hit_adr", 32'(bus.hit_adr), e_hadr);
      if (bus.rd_en === 1'b1) n_reads++;
      if (bus.done === 1'b1) begin
        done_seen   = 1'b1;
        done_at     = cyc;
        obs_hit     = bus.hit;
        obs_hit_adr = int'(bus.hit_adr);
      end
    end
  end

  task automatic run_scan(input int s, input int e, input bit sm, input int k,
                          input bit hold, input int x_done, input int x_reads,
                          input bit x_hit, input int x_hadr);
    @(negedge clk);
    bus.start_adr = 5'(s);
    bus.end_adr   = 5'(e);
    bus.same      = sm;
    bus.key       = 8'(k);
    bus.go        = 1'b1;
    @(negedge clk);
    if (hold) @(negedge clk);
    bus.go  = 1'b0;
    bus.key = ~bus.key;
    for (int i = 0; i < 80 && !done_seen; i++) @(negedge clk);
    chk("timeout", 32'(done_seen), 32'd1);
    chk("done_cycle", done_at, x_done);
    chk("read_count", n_reads, x_reads);
    chk("final_hit", 32'(obs_hit), 32'(x_hit));
    chk("final_hit_adr", obs_hit_adr, x_hadr);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    mem[5]  = 8'hA5;
    mem[9]  = 8'h3C;
    mem[2]  = 8'h5A;
    mem[3]  = 8'h5A;
    mem[31] = 8'hC3;

    reset         = 1'b0;
    bus.go        = 1'b0;
    bus.start_adr = '0;
    bus.end_adr   = '0;
    bus.same      = 1'b0;
    bus.key       = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy",    32'(bus.busy),    32'd0);
    chk("reset_rd_en",   32'(bus.rd_en),   32'd0);
    chk("reset_hit_adr", 32'(bus.hit_adr), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_scan( 3,  6, 1'b0, 8'hA5, 1'b0,  5,  3, 1'b1,  5);
    run_scan(28, 31, 1'b0, 8'h77, 1'b0,  6,  4, 1'b0,  0);
    run_scan( 9, 20, 1'b1, 8'h3C, 1'b0,  3,  1, 1'b1,  9);
    run_scan(10,  4, 1'b0, 8'h11, 1'b1,  1,  0, 1'b0,  0);
    run_scan( 0,  7, 1'b0, 8'h5A, 1'b0,  5,  3, 1'b1,  2);
    run_scan(20, 31, 1'b0, 8'hC3, 1'b0, 14, 12, 1'b1, 31);
    run_scan(31, 31, 1'b0, 8'h44, 1'b0,  3,  1, 1'b0,  0);

    // go mid-scan is ignored, then reset aborts the scan in cycle 3
    @(negedge clk);
    bus.start_adr = 5'd0;
    bus.end_adr   = 5'd31;
    bus.same      = 1'b0;
    bus.key       = 8'hEE;
    bus.go        = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    @(negedge clk);
    bus.start_adr = 5'd9;
    bus.key       = 8'h3C;
    bus.go        = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    chk("pre_reset_rd_adr", 32'(bus.rd_adr), 32'd2);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rd_en", 32'(bus.rd_en), 32'd0);
    chk("abort_busy",  32'(bus.busy),  32'd0);
    chk("abort_done",  32'(bus.done),  32'd0);
    chk("abort_hit",   32'(bus.hit),   32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_done_after_reset", 32'(done_seen), 32'd0);
    run_scan( 0,  7, 1'b0, 8'h5A, 1'b0,  5,  3, 1'b1,  2);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
